// File: rtl/wfg_interconnect_pkg.sv
// Shared interconnect types used by the wfg stream blocks.
package wfg_interconnect_pkg;

  typedef struct packed {
    logic        tvalid;
    logic [31:0] tdata;
  } axis_t;

endpackage

// File: rtl/wfg_record_spi_pkg.sv
// Register map, configuration layout and word-size decode for the SPI recorder.
package wfg_record_spi_pkg;

  localparam logic [3:0] REG_CTRL   = 4'h0;
  localparam logic [3:0] REG_CFG    = 4'h4;
  localparam logic [3:0] REG_STATUS = 4'h8;
  localparam logic [3:0] REG_COUNT  = 4'hC;

  typedef struct packed {
    logic [1:0] dff;
    logic       lsbfirst;
    logic       cpha;
    logic       cpol;
  } cfg_t;

  localparam cfg_t CFG_RESET = '{dff: 2'd3, lsbfirst: 1'b0, cpha: 1'b0, cpol: 1'b0};

  // Word length in bits: (dff + 1) * 8
  function automatic logic [5:0] word_bits(input logic [1:0] dff);
    return {1'b0, dff, 3'b000} + 6'd8;
  endfunction

endpackage

// File: rtl/wfg_record_spi_wishbone_reg.sv
// Wishbone slave holding CTRL/CFG/STATUS/COUNT for the SPI recorder.
module wfg_record_spi_wishbone_reg
  import wfg_record_spi_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stb,
  input  logic        cyc,
  input  logic        we,
  input  logic [3:0]  adr,
  input  logic [4:0]  wdata,
  output logic        ack,
  output logic [31:0] rdata,
  output logic        en,
  output cfg_t        cfg,
  input  logic        word_load,
  input  logic        ovf_set
);

  logic        ack_r;
  logic        en_r;
  logic        ovf_r;
  logic [31:0] rdata_r;
  logic [31:0] count_r;
  cfg_t        cfg_r;
  logic        req_s;
  logic        wr_s;
  logic [31:0] rd_mux_s;

  // Request qualification and read-data mux
  always_comb begin
    req_s = stb & cyc & ~ack_r;
    wr_s  = req_s & we;
    case (adr)
      REG_CTRL:   rd_mux_s = {31'd0, en_r};
      REG_CFG:    rd_mux_s = {26'd0, cfg_r.dff, 1'b0, cfg_r.lsbfirst, cfg_r.cpha, cfg_r.cpol};
      REG_STATUS: rd_mux_s = {31'd0, ovf_r};
      REG_COUNT:  rd_mux_s = count_r;
      default:    rd_mux_s = 32'd0;
    endcase
  end

  // Handshake, register writes, sticky overflow (set beats clear) and word counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_r   <= 1'b0;
      rdata_r <= 32'd0;
      en_r    <= 1'b0;
      cfg_r   <= CFG_RESET;
      ovf_r   <= 1'b0;
      count_r <= 32'd0;
    end else begin
      ack_r   <= req_s;
      rdata_r <= (req_s && !we) ? rd_mux_s : 32'd0;
      if (wr_s && adr == REG_CTRL) en_r <= wdata[0];
      if (wr_s && adr == REG_CFG) cfg_r <= cfg_t'(wdata);
      if (ovf_set) ovf_r <= 1'b1;
      else if (wr_s && adr == REG_STATUS && wdata[0]) ovf_r <= 1'b0;
      if (word_load) count_r <= count_r + 32'd1;
    end
  end

  assign ack   = ack_r;
  assign rdata = rdata_r;
  assign en    = en_r;
  assign cfg   = cfg_r;

endmodule

// File: rtl/wfg_record_spi_top.sv
// SPI slave recorder: synchronizes an external SPI bus, assembles words and
// presents them on an AXI-stream master with overflow tracking.
module wfg_record_spi_top
  import wfg_record_spi_pkg::*;
  import wfg_interconnect_pkg::*;
#(
  parameter int BUSW = 32
) (
  input  logic            wb_clk_i,
  input  logic            wb_rst_ni,
  input  logic            wbs_stb_i,
  input  logic            wbs_cyc_i,
  input  logic            wbs_we_i,
  input  logic [3:0]      wbs_sel_i,
  input  logic [BUSW-1:0] wbs_adr_i,
  input  logic [BUSW-1:0] wbs_dat_i,
  output logic            wbs_ack_o,
  output logic [BUSW-1:0] wbs_dat_o,
  input  logic            wfg_record_spi_sclk_i,
  input  logic            wfg_record_spi_cs_ni,
  input  logic            wfg_record_spi_sdi_i,
  input  logic            wfg_axis_tready_i,
  output logic            wfg_axis_tvalid_o,
  output logic [31:0]     wfg_axis_tdata_o
);

  logic [1:0]  sclk_sync_r, cs_sync_r, sdi_sync_r;
  logic        sclk_prev_r, cs_prev_r, armed_r;
  logic [2:0]  ready_r;
  logic [5:0]  bit_cnt_r;
  logic [31:0] shift_r;
  axis_t       axis_r;
  logic [31:0] rdata_s, shift_next_s;
  logic        en_s, rise_s, fall_s, sample_s, cs_fall_s, cs_rise_s;
  logic        capture_s, done_s, accept_s, load_s, ovf_set_s;
  cfg_t        cfg_s;
  logic        unused_s;

  assign unused_s = ^{wbs_sel_i, wbs_adr_i[BUSW-1:4], wbs_dat_i[BUSW-1:6], wbs_dat_i[3]};

  wfg_record_spi_wishbone_reg u_regs (
    .clk       (wb_clk_i),
    .rst_n     (wb_rst_ni),
    .stb       (wbs_stb_i),
    .cyc       (wbs_cyc_i),
    .we        (wbs_we_i),
    .adr       (wbs_adr_i[3:0]),
    .wdata     ({wbs_dat_i[5:4], wbs_dat_i[2:0]}),
    .ack       (wbs_ack_o),
    .rdata     (rdata_s),
    .en        (en_s),
    .cfg       (cfg_s),
    .word_load (load_s),
    .ovf_set   (ovf_set_s)
  );

  assign wbs_dat_o = BUSW'(rdata_s);

  // Edge detection, sample-edge selection and word completion
  always_comb begin
    rise_s    = ready_r[2] & sclk_sync_r[1] & ~sclk_prev_r;
    fall_s    = ready_r[2] & ~sclk_sync_r[1] & sclk_prev_r;
    cs_fall_s = ready_r[2] & cs_prev_r & ~cs_sync_r[1];
    cs_rise_s = ready_r[2] & ~cs_prev_r & cs_sync_r[1];
    if (cfg_s.cpha == cfg_s.cpol) begin
      sample_s = rise_s;
    end else begin
      sample_s = fall_s;
    end
    capture_s = en_s & armed_r & ~cs_sync_r[1] & sample_s;
    if (cfg_s.lsbfirst) begin
      shift_next_s = shift_r | (32'(sdi_sync_r[1]) << bit_cnt_r);
    end else begin
      shift_next_s = {shift_r[30:0], sdi_sync_r[1]};
    end
    done_s    = capture_s & ((bit_cnt_r + 6'd1) >= word_bits(cfg_s.dff));
    accept_s  = axis_r.tvalid & wfg_axis_tready_i;
    load_s    = done_s & (~axis_r.tvalid | accept_s);
    ovf_set_s = done_s & axis_r.tvalid & ~wfg_axis_tready_i;
  end

  // Synchronizers and bit assembly; armed_r keeps a frame already in progress
  // at reset release from being captured.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      sclk_sync_r <= 2'b00;
      cs_sync_r   <= 2'b11;
      sdi_sync_r  <= 2'b00;
      sclk_prev_r <= 1'b0;
      cs_prev_r   <= 1'b1;
      ready_r     <= 3'b000;
      armed_r     <= 1'b0;
      bit_cnt_r   <= 6'd0;
      shift_r     <= 32'd0;
    end else begin
      sclk_sync_r <= {sclk_sync_r[0], wfg_record_spi_sclk_i};
      cs_sync_r   <= {cs_sync_r[0], wfg_record_spi_cs_ni};
      sdi_sync_r  <= {sdi_sync_r[0], wfg_record_spi_sdi_i};
      sclk_prev_r <= sclk_sync_r[1];
      cs_prev_r   <= cs_sync_r[1];
      ready_r     <= {ready_r[1:0], 1'b1};
      if (cs_fall_s) armed_r <= 1'b1;
      else if (cs_rise_s) armed_r <= 1'b0;
      if (!en_s || cs_fall_s || cs_rise_s || done_s) begin
        bit_cnt_r <= 6'd0;
        shift_r   <= 32'd0;
      end else if (capture_s) begin
        bit_cnt_r <= bit_cnt_r + 6'd1;
        shift_r   <= shift_next_s;
      end
    end
  end

  // AXI-stream holding register
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      axis_r <= '{tvalid: 1'b0, tdata: 32'd0};
    end else if (load_s) begin
      axis_r <= '{tvalid: 1'b1, tdata: shift_next_s};
    end else if (accept_s) begin
      axis_r.tvalid <= 1'b0;
    end
  end

  assign wfg_axis_tvalid_o = axis_r.tvalid;
  assign wfg_axis_tdata_o  = axis_r.tdata;

endmodule

// File: doc/wfg_record_spi_top.md
WFG_RECORD_SPI_TOP -- requirements
Module: wfg_record_spi_top

Interface
REQ-001 SHALL have parameter BUSW, default 32, Wishbone data/address width.
REQ-002 SHALL have port wb_clk_i  in  1  sole clock, rising edge.
REQ-003 SHALL have port wb_rst_ni  in  1  asynchronous active-low reset.
REQ-004 SHALL have ports wbs_stb_i, wbs_cyc_i, wbs_we_i  in  1  Wishbone strobe, cycle and write-enable.
REQ-005 SHALL have ports wbs_sel_i  in  4 (byte select, ignored); wbs_adr_i  in  BUSW (only bits [3:0] decoded); wbs_dat_i  in  BUSW (write data).
REQ-006 SHALL have ports wbs_ack_o  out  1 (acknowledge) and wbs_dat_o  out  BUSW (read data).
REQ-007 SHALL have ports wfg_record_spi_sclk_i, wfg_record_spi_cs_ni, wfg_record_spi_sdi_i  in  1  external SPI clock, chip select and data; all asynchronous.
REQ-008 SHALL have AXI-stream master ports wfg_axis_tready_i  in  1; wfg_axis_tvalid_o  out  1; wfg_axis_tdata_o  out  32.

Function
REQ-009 Register map:
- 0x0 CTRL: bit0 EN.
- 0x4 CFG: bit0 CPOL, bit1 CPHA, bit2 LSBFIRST, bits[5:4] DFF (word = (DFF+1)*8 bits).
- 0x8 STATUS: bit0 OVF, sticky, write-1-to-clear.
- 0xC COUNT: read-only, 32-bit count of captured words.
- Reads of unmapped offsets return 0; writes to them are ignored.
REQ-010 Wishbone handshake:
- wbs_ack_o pulses high for exactly one cycle, one cycle after a cycle with stb&cyc&!ack.
- Write data takes effect on the ack cycle.
- wbs_dat_o is valid while ack is high.
REQ-011 SCLK, CS_N and SDI SHALL each pass through a 2-flop synchronizer; edge detection SHALL compare the synchronized SCLK with its one-cycle-delayed copy.
REQ-012 SPI sample edge selection:
- Leading edge is rising when CPOL=0, falling when CPOL=1.
- Sample on the leading edge when CPHA=0, on the trailing edge when CPHA=1.
- Supported SCLK frequency is at most wb_clk_i/4.
REQ-013 A synchronized CS_N falling edge SHALL clear the bit counter and the shift register.
REQ-014 Bit capture:
- A bit is captured only on a sample edge with EN=1 and synchronized CS_N low.
- LSBFIRST=0: shift in at bit 0.
- LSBFIRST=1: the n-th received bit goes to bit n.
REQ-015 Word completion:
- When the bit count reaches the word size, the word is zero-extended to 32 bits in tdata.
- The bit counter restarts for back-to-back words.
- COUNT increments and wraps from 0xFFFFFFFF to 0.
- wfg_axis_tvalid_o rises on the cycle after the completing sample edge.
REQ-016 tvalid SHALL stay high with tdata stable until a cycle with tvalid&tready; it deasserts after that cycle unless a new word is loaded on the same cycle.
REQ-017 If a word completes on the same cycle as an accept (tvalid&tready), the new word SHALL load, tvalid SHALL stay high and OVF SHALL not set.
REQ-018 If a word completes while tvalid=1 and tready=0, the new word SHALL be dropped, OVF SHALL set, COUNT SHALL not increment and the held word SHALL be preserved.
REQ-019 A CS_N rising edge mid-word SHALL discard the partial word; no tvalid results.
REQ-020 EN=0 SHALL hold the bit counter and shift register cleared; a pending tvalid word SHALL remain until accepted.
REQ-021 If an OVF set event and a W1C write to STATUS occur on the same cycle, set SHALL win.

Reset
REQ-022 Asserting wb_rst_ni SHALL immediately clear every flop. All outputs SHALL reset to 0: ack, wbs_dat_o, tvalid, tdata.
REQ-023 Register reset values: CTRL=0; CFG: CPOL=0, CPHA=0, LSBFIRST=0, DFF=3 (32-bit words); STATUS=0; COUNT=0. Synchronizers SHALL reset to CS_N=1, SCLK=0, SDI=0.
REQ-024 Reset asserted mid-word or mid-handshake SHALL drop all state with no tvalid glitch; after release, capture SHALL begin only at the next CS_N falling edge.

Structure
REQ-025 Register offsets, the CFG field struct and the word-size decode SHALL live in wfg_record_spi_pkg; axis_t SHALL come from the shared interconnect package.
REQ-026 Wishbone decode and the registers SHALL be the sub-module wfg_record_spi_wishbone_reg; the SPI capture logic and the AXIS output SHALL live in wfg_record_spi_top.

Verification
REQ-027 Basic 8-bit capture:
- Stimulus: CFG=0x00 (CPOL=0, CPHA=0, MSB first, DFF=0), EN=1; send 0xA5 at wb_clk/8.
- Response: tdata=0x000000A5, tvalid stays high until tready; COUNT=1.
REQ-028 Mode 3, LSB first, 32-bit:
- Stimulus: CFG=0x37 (CPOL=1, CPHA=1, LSBFIRST=1, DFF=3); send bits of 0x12345678 LSB first.
- Response: tdata=0x12345678.
REQ-029 Overflow:
- Stimulus: tready=0; send 0x11 then 0x22 (8-bit mode).
- Response: tdata stays 0x11, OVF=1, COUNT=1; writing 0x1 to STATUS reads back 0.
REQ-030 Simultaneous load and accept:
- Stimulus: back-to-back 16-bit words 0xBEEF and 0xCAFE; tready pulses on the exact cycle the second word completes.
- Response: tvalid stays high, tdata=0xCAFE, OVF=0.
REQ-031 Aborted word:
- Stimulus: CS_N rises after 5 bits; then a full 0x3C is sent.
- Response: only 0x3C is emitted; COUNT=1.
REQ-032 Reset mid-word:
- Stimulus: wb_rst_ni low for 2 cycles during bit 4; then a full 0x81 is sent after a new CS_N falling edge.
- Response: outputs 0 during reset; only 0x81 is emitted afterward.
